// File: rtl/cv32e40p_tb_ctrl_pkg.sv
// Shared constants and enums for the testbench control peripheral.
package cv32e40p_tb_ctrl_pkg;

  localparam logic [2:0] OFF_STDOUT   = 3'd0;
  localparam logic [2:0] OFF_EXIT     = 3'd1;
  localparam logic [2:0] OFF_TESTSTAT = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_CYCLES   = 3'd4;

  localparam logic [31:0] PASS_MAGIC   = 32'd123456789;
  localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } tb_ctrl_state_e;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_PASS = 2'd1,
    KIND_FAIL = 2'd2,
    KIND_EXIT = 2'd3
  } tb_ctrl_kind_e;

endpackage

// File: rtl/cv32e40p_tb_ctrl_fifo.sv
// Synchronous FIFO with wrap-around pointers; head is visible the cycle after a push.
module cv32e40p_tb_ctrl_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  // Gate the head so the output is 0 while nothing is queued.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_tb_ctrl_periph.sv
// Testbench control peripheral: stdout stream, pass/fail/exit status, cycle counter.
// Optional watchdog timeout compiled in with CV32E40P_TB_CTRL_WATCHDOG_EN.
module cv32e40p_tb_ctrl_periph
  import cv32e40p_tb_ctrl_pkg::*;
#(
  parameter int unsigned STDOUT_DEPTH = 8,
  parameter logic [31:0] WDOG_CYCLES  = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned CW = $clog2(STDOUT_DEPTH) + 1;

  logic [2:0]     offset;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           wr_stdout, push, pop, term_wr, wdog_hit, timeout_flag, done;
  tb_ctrl_state_e state_q, state_d;
  tb_ctrl_kind_e  kind_q, kind_d;
  logic [31:0]    value_q, value_d;
  logic [31:0]    cycles_q, rd_data, rdata_q;
  logic           rvalid_q;
  logic           unused_bits;

  assign offset       = addr_i[4:2];
  assign wr_stdout    = req_i && we_i && (offset == OFF_STDOUT);
  // Registered full flag only: a pop in this cycle does not unblock a push.
  assign gnt_o        = req_i && !(wr_stdout && fifo_full);
  assign push         = gnt_o && wr_stdout && be_i[0];
  assign pop          = !fifo_empty && char_ready_i;
  assign term_wr      = gnt_o && we_i && ((offset == OFF_EXIT) || (offset == OFF_TESTSTAT));
  assign char_valid_o = !fifo_empty;
  assign unused_bits  = ^{be_i[3:1], addr_i[31:5], addr_i[1:0]};

  cv32e40p_tb_ctrl_fifo #(
    .DEPTH (STDOUT_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (char_o),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CV32E40P_TB_CTRL_WATCHDOG_EN
  logic [31:0] wdog_q;
  logic        timeout_q;

  assign wdog_hit     = (state_q == RUN) && (wdog_q == WDOG_CYCLES);
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == RUN) wdog_q <= wdog_q + 32'd1;
      // A terminal write in the same cycle wins over the timeout.
      if (wdog_hit && !term_wr) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog  = ^WDOG_CYCLES;
  assign wdog_hit     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    value_d = value_q;
    case (state_q)
      RUN: begin
        if (term_wr) begin
          state_d = DRAIN;
          if (offset == OFF_EXIT) begin
            kind_d  = KIND_EXIT;
            value_d = wdata_i;
          end else begin
            kind_d  = (wdata_i == PASS_MAGIC) ? KIND_PASS : KIND_FAIL;
            value_d = '0;
          end
        end else if (wdog_hit) begin
          state_d = DRAIN;
          kind_d  = KIND_FAIL;
          value_d = TIMEOUT_CODE;
        end
      end
      DRAIN: if (fifo_empty) state_d = DONE;
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (gnt_o && !we_i) begin
      case (offset)
        OFF_STATUS: rd_data = {state_q, timeout_flag, 13'b0, 16'(fifo_count)};
        OFF_CYCLES: rd_data = cycles_q;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      kind_q   <= KIND_NONE;
      value_q  <= '0;
      cycles_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      value_q  <= value_d;
      cycles_q <= cycles_q + 32'd1;
      rvalid_q <= gnt_o;
      rdata_q  <= rd_data;
    end
  end

  assign done           = (state_q == DONE);
  assign tests_passed_o = done && (kind_q == KIND_PASS);
  assign tests_failed_o = done && (kind_q == KIND_FAIL);
  assign exit_valid_o   = done && (kind_q == KIND_EXIT);
  assign exit_value_o   = done ? value_q : '0;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;

endmodule

// File: tb/tb_cv32e40p_tb_ctrl_periph.sv
// Randomized + directed bench; a queue-based reference model predicts every output each cycle.
module tb_cv32e40p_tb_ctrl_periph;

  localparam int DEPTH = 8;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, char_ready_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        gnt_o, rvalid_o, char_valid_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] rdata_o, exit_value_o;
  logic [7:0]  char_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  chq[$];
  logic [31:0] respq[$];
  int          mstate = 0;  // 0 RUN, 1 DRAIN, 2 DONE
  int          mkind = 0;   // 1 pass, 2 fail, 3 exit
  logic [31:0] mval = '0;
  logic [31:0] cyc = '0;
  int          wd = 0;
  bit          mto = 1'b0;
  bit          chk_en = 1'b0;
  bit          rand_on = 1'b0;

  always #5 clk = ~clk;

  cv32e40p_tb_ctrl_periph #(
    .STDOUT_DEPTH (DEPTH),
    .WDOG_CYCLES  (32'd100)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .char_valid_o   (char_valid_o),
    .char_o         (char_o),
    .char_ready_i   (char_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    logic [31:0] v;
    v = '0;
    if (off == 3'd3) begin
      v[31:30] = 2'(mstate);
      v[29]    = mto;
      v[15:0]  = 16'(chq.size());
    end else if (off == 3'd4) begin
      v = cyc;
    end
    return v;
  endfunction

  // Model update on each clock edge using the inputs held during the cycle.
  always @(posedge clk) begin
    logic [2:0] off;
    bit g, pop, term;
    int old_state;
    off = addr_i[4:2];
    if (!rst_ni) begin
      chq.delete(); respq.delete();
      mstate = 0; mkind = 0; mval = '0; cyc = '0; wd = 0; mto = 1'b0;
    end else begin
      g = req_i && !(we_i && off == 3'd0 && chq.size() == DEPTH);
      pop = (chq.size() != 0) && char_ready_i;
      term = g && we_i && (off == 3'd1 || off == 3'd2);
      if (g) respq.push_back(we_i ? 32'd0 : model_read(off));
      old_state = mstate;
      if (mstate == 0) begin
        if (term) begin
          mstate = 1;
          if (off == 3'd1) begin mkind = 3; mval = wdata_i; end
          else begin mkind = (wdata_i == MAGIC) ? 1 : 2; mval = '0; end
        end
`ifdef CV32E40P_TB_CTRL_WATCHDOG_EN
        else if (wd == 100) begin
          mstate = 1; mkind = 2; mval = 32'hDEAD_0001; mto = 1'b1;
        end
`endif
      end else if (mstate == 1 && chq.size() == 0) begin
        mstate = 2;
      end
      if (old_state == 0) wd++;
      if (pop) void'(chq.pop_front());
      if (g && we_i && off == 3'd0 && be_i[0]) chq.push_back(wdata_i[7:0]);
      cyc = cyc + 32'd1;
    end
  end

  // Monitor: responses popped from the scoreboard, streams and status compared.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("rvalid", {31'd0, rvalid_o}, {31'd0, respq.size() != 0});
      if (respq.size() != 0) chk("rdata", rdata_o, respq.pop_front());
      else chk("rdata_idle", rdata_o, 32'd0);
      chk("char_valid", {31'd0, char_valid_o}, {31'd0, chq.size() != 0});
      if (chq.size() != 0) chk("char", {24'd0, char_o}, {24'd0, chq[0]});
      else chk("char_idle", {24'd0, char_o}, 32'd0);
      chk("passed", {31'd0, tests_passed_o}, {31'd0, mstate == 2 && mkind == 1});
      chk("failed", {31'd0, tests_failed_o}, {31'd0, mstate == 2 && mkind == 2});
      chk("exit_valid", {31'd0, exit_valid_o}, {31'd0, mstate == 2 && mkind == 3});
      chk("exit_value", exit_value_o, (mstate == 2) ? mval : 32'd0);
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en && rst_ni)
      chk("gnt", {31'd0, gnt_o},
          {31'd0, req_i && !(we_i && addr_i[4:2] == 3'd0 && chq.size() == DEPTH)});
  end

  task automatic bus(input bit we, input logic [2:0] off, input logic [31:0] d,
                     input logic [3:0] be);
    int n;
    n = 0;
    req_i = 1'b1; we_i = we; wdata_i = d; be_i = be;
    addr_i = $urandom;
    addr_i[4:2] = off;
    #1;
    while (!gnt_o && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt_o) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: got gnt 0 expected 1 off=%0d", off);
    end else begin
      $display("txn %s off=%0d data=%08h be=%h", we ? "WR" : "RD", off, d, be);
    end
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic do_reset();
    req_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2);

    // Randomized traffic with a randomly toggling consumer.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 45) bus(1'b1, 3'd0, $urandom, ($urandom_range(0, 4) == 0) ? 4'he : 4'hf);
          else if (r < 65) bus(1'b0, 3'd3, 32'd0, 4'hf);
          else if (r < 75) bus(1'b0, 3'd4, 32'd0, 4'hf);
          else if (r < 85) bus(1'($urandom_range(0, 1)), 3'($urandom_range(5, 7)), $urandom, 4'hf);
          else if (r < 90) bus(1'b0, 3'($urandom_range(0, 2)), 32'd0, 4'hf);
          else idle(1);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          char_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus(1'b1, 3'd2, ($urandom_range(0, 1) == 1) ? MAGIC : $urandom, 4'hf);
    char_ready_i = 1'b1;
    idle(30);

    // 'H','i' stream then STATUS
    do_reset();
    bus(1'b1, 3'd0, 32'h48, 4'hf);
    bus(1'b1, 3'd0, 32'h69, 4'hf);
    idle(2);
    bus(1'b0, 3'd3, 32'd0, 4'hf);

    // Nine pushes into a full FIFO, one pop releases the last
    char_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) bus(1'b1, 3'd0, 32'h30 + i, 4'hf);
      end
      begin
        idle(15);
        char_ready_i = 1'b1;
        idle(1);
        char_ready_i = 1'b0;
      end
    join
    bus(1'b0, 3'd3, 32'd0, 4'hf);
    char_ready_i = 1'b1;
    idle(12);

    // Pass held back until three queued bytes drain
    do_reset();
    char_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b1, 3'd0, 32'h61 + i, 4'hf);
    bus(1'b1, 3'd2, MAGIC, 4'hf);
    idle(4);
    char_ready_i = 1'b1;
    idle(8);

    // First terminal write wins
    do_reset();
    bus(1'b1, 3'd1, 32'd5, 4'hf);
    bus(1'b1, 3'd2, MAGIC, 4'hf);
    idle(4);
    bus(1'b0, 3'd3, 32'd0, 4'hf);

    // Reset mid-drain
    do_reset();
    char_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) bus(1'b1, 3'd0, 32'h41 + i, 4'hf);
    bus(1'b1, 3'd1, 32'd7, 4'hf);
    idle(2);
    do_reset();
    bus(1'b0, 3'd3, 32'd0, 4'hf);
    char_ready_i = 1'b1;

    // Idle long enough for the watchdog, if built in
    do_reset();
    idle(150);
    bus(1'b0, 3'd3, 32'd0, 4'hf);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
